// File: rtl/debug_target_emu.sv
// debug_target_emu: target-side controller emulator used for board and simulation bring-up.
// It accepts decoded debugger commands and stays busy for a fixed number of cycles.
// It then executes pause/resume or a register/memory access against internal arrays.
// Each completion returns d_rd/error, and a short command history is kept for display.
module debug_target_emu #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int NUM_REGS    = 32,
  parameter int BUSY_CYCLES = 8,
  parameter int HIST_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  input  logic [3:0]              cmd,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       d_in,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       d_rd,
  output logic                    error,
  output logic                    paused,
  output logic [4*HIST_DEPTH-1:0] hist,
  output logic [15:0]             cmd_count,
  output logic [7:0]              overrun
);

  localparam int MIDX_W = $clog2(MEM_DEPTH);
  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W  = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam int HIST_W = 4 * HIST_DEPTH;

  // Range limits carry one or two extra bits so that the full address can be compared without overflow.
  localparam logic [ADDR_W+1:0] MEM_BYTES = (ADDR_W+2)'(4 * MEM_DEPTH);
  localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(NUM_REGS);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BUSY_CYCLES - 1);

  localparam logic [3:0] CMD_PAUSE  = 4'd1;
  localparam logic [3:0] CMD_RESUME = 4'd2;
  localparam logic [3:0] CMD_MEM_RD = 4'd3;
  localparam logic [3:0] CMD_MEM_WR = 4'd4;
  localparam logic [3:0] CMD_REG_RD = 4'd5;
  localparam logic [3:0] CMD_REG_WR = 4'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   d_rd_q, d_rd_d;
  logic                error_q, error_d;
  logic                paused_q, paused_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [15:0]         cmd_count_q, cmd_count_d;
  logic [7:0]          overrun_q, overrun_d;

  logic [DATA_W-1:0]   mem_q  [MEM_DEPTH];
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                mem_we;
  logic                reg_we;

  // Decoded view of the latched command.
  logic [MIDX_W-1:0]   mem_idx;
  logic [RIDX_W-1:0]   reg_idx;
  logic                mem_bad;
  logic                reg_bad;
  logic                ex_error;
  logic                ex_rd_en;
  logic [DATA_W-1:0]   ex_rd_data;
  logic                ex_mem_wr;
  logic                ex_reg_wr;
  logic                ex_paused;
  logic [HIST_W-1:0]   hist_push;

  // Only the low bits index the arrays; the upper bits are covered by the range checks below.
  assign mem_idx = addr_q[MIDX_W+1:2];
  assign reg_idx = addr_q[RIDX_W-1:0];
  assign mem_bad = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q} >= MEM_BYTES);
  assign reg_bad = ({1'b0, addr_q} >= REG_LIMIT);

  // The newest command enters at the low nibble, and older entries shift toward the MSB.
  generate
    if (HIST_DEPTH == 1) begin : g_hist_one
      assign hist_push = cmd;
    end else begin : g_hist_shift
      assign hist_push = {hist_q[HIST_W-5:0], cmd};
    end
  endgenerate

  // Command execution: compute the result of the latched command from the current paused state.
  always_comb begin
    ex_error   = 1'b0;
    ex_rd_en   = 1'b0;
    ex_rd_data = '0;
    ex_mem_wr  = 1'b0;
    ex_reg_wr  = 1'b0;
    ex_paused  = paused_q;
    case (cmd_q)
      CMD_PAUSE:  ex_paused = 1'b1;
      CMD_RESUME: ex_paused = 1'b0;
      CMD_MEM_RD: begin
        if (!paused_q || mem_bad) begin
          ex_error = 1'b1;
        end else begin
          ex_rd_en   = 1'b1;
          ex_rd_data = mem_q[mem_idx];
        end
      end
      CMD_MEM_WR: begin
        if (!paused_q || mem_bad) ex_error = 1'b1;
        else                      ex_mem_wr = 1'b1;
      end
      CMD_REG_RD: begin
        if (!paused_q || reg_bad) begin
          ex_error = 1'b1;
        end else begin
          ex_rd_en   = 1'b1;
          ex_rd_data = (reg_idx == '0) ? '0 : regs_q[reg_idx];
        end
      end
      CMD_REG_WR: begin
        // Register 0 is hardwired to zero, so a write to it completes cleanly without changing anything.
        if (!paused_q || reg_bad) ex_error = 1'b1;
        else                      ex_reg_wr = (reg_idx != '0);
      end
      default: ex_error = 1'b1;
    endcase
  end

  // FSM next-state logic: accept in IDLE/DONE, count down in EXEC, and commit the results on the EXEC->DONE edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    din_d       = din_q;
    d_rd_d      = d_rd_q;
    error_d     = error_q;
    paused_d    = paused_q;
    hist_d      = hist_q;
    cmd_count_d = cmd_count_q;
    overrun_d   = overrun_q;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    case (state_q)
      S_EXEC: begin
        if (cmd_valid && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          error_d  = ex_error;
          paused_d = ex_paused;
          mem_we   = ex_mem_wr;
          reg_we   = ex_reg_wr;
          if (ex_rd_en) d_rd_d = ex_rd_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (cmd_valid) begin
          state_d     = S_EXEC;
          cnt_d       = CNT_LOAD;
          cmd_d       = cmd;
          addr_d      = addr;
          din_d       = d_in;
          hist_d      = hist_push;
          cmd_count_d = cmd_count_q + 16'd1;
        end
      end
    endcase
  end

  // Control and status registers; an asynchronous reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      d_rd_q      <= '0;
      error_q     <= 1'b0;
      paused_q    <= 1'b0;
      hist_q      <= '0;
      cmd_count_q <= '0;
      overrun_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      d_rd_q      <= d_rd_d;
      error_q     <= error_d;
      paused_q    <= paused_d;
      hist_q      <= hist_d;
      cmd_count_q <= cmd_count_d;
      overrun_q   <= overrun_d;
    end
  end

  // Emulated memory: cleared on reset and written only when a MEM_WR completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_idx] <= din_q;
    end
  end

  // Emulated register file: cleared on reset; entry 0 is never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[reg_idx] <= din_q;
    end
  end

  assign busy      = (state_q == S_EXEC);
  assign done      = (state_q == S_DONE);
  assign d_rd      = d_rd_q;
  assign error     = error_q;
  assign paused    = paused_q;
  assign hist      = hist_q;
  assign cmd_count = cmd_count_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_debug_target_emu.sv
// Directed testbench for debug_target_emu using its default parameters.
module tb_debug_target_emu;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic        busy;
  logic        done;
  logic [31:0] d_rd;
  logic        error;
  logic        paused;
  logic [15:0] hist;
  logic [15:0] cmd_count;
  logic [7:0]  overrun;

  int n_checks = 0;
  int n_err    = 0;
  int n_done;

  debug_target_emu dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .addr      (addr),
    .d_in      (d_in),
    .busy      (busy),
    .done      (done),
    .d_rd      (d_rd),
    .error     (error),
    .paused    (paused),
    .hist      (hist),
    .cmd_count (cmd_count),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command strobe that the DUT samples at the next rising edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    addr      = a;
    d_in      = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Wait up to a bounded number of cycles for done, and return at the falling edge inside the DONE cycle.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic do_cmd(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    issue(c, a, d);
    wait_done(tag);
    $display("cmd %0h addr=%08h din=%08h -> d_rd=%08h error=%0b paused=%0b count=%0d", c, a, d, d_rd, error, paused, cmd_count);
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 4'd0;
    addr      = 32'd0;
    d_in      = 32'd0;

    // Check the state while reset is asserted.
    #22;
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_d_rd",  64'(d_rd), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_paused",64'(paused), 64'd0);
    check("rst_hist",  64'(hist), 64'd0);
    check("rst_count", 64'(cmd_count), 64'd0);
    check("rst_ovr",   64'(overrun), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Test 1: PAUSE timing. Busy is high for 8 cycles and done follows in the 9th.
    issue(4'd1, 32'd0, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("t1_busy_%0d", k), 64'({busy, done}), 64'b10);
    end
    @(negedge clk);
    check("t1_done",   64'({busy, done}), 64'b01);
    check("t1_paused", 64'(paused), 64'd1);
    check("t1_error",  64'(error), 64'd0);
    check("t1_hist",   64'(hist), 64'h0001);
    check("t1_count",  64'(cmd_count), 64'd1);
    $display("PAUSE timing: busy 8 cycles then done, paused=%0b", paused);

    // Test 2: memory write/read, including the last word.
    do_cmd("t2_wr8", 4'd4, 32'h8, 32'hDEADBEEF);
    check("t2_wr8_err", 64'(error), 64'd0);
    do_cmd("t2_rd8", 4'd3, 32'h8, 32'd0);
    check("t2_rd8_data", 64'(d_rd), 64'hDEADBEEF);
    check("t2_rd8_err",  64'(error), 64'd0);
    check("t2_hist",     64'(hist), 64'h0143);
    check("t2_count",    64'(cmd_count), 64'd3);
    do_cmd("t2_wr3c", 4'd4, 32'h3C, 32'hA5A50F0F);
    do_cmd("t2_rdc",  4'd3, 32'hC, 32'd0);
    check("t2_rdc_data", 64'(d_rd), 64'h0);
    do_cmd("t2_rd3c", 4'd3, 32'h3C, 32'd0);
    check("t2_rd3c_data", 64'(d_rd), 64'hA5A50F0F);
    check("t2_rd3c_err",  64'(error), 64'd0);

    // Test 3: misaligned and out-of-range memory addresses. Each sets error and leaves d_rd unchanged.
    do_cmd("t3_mis", 4'd3, 32'h6, 32'd0);
    check("t3_mis_err",  64'(error), 64'd1);
    check("t3_mis_data", 64'(d_rd), 64'hA5A50F0F);
    do_cmd("t3_oor", 4'd3, 32'h40, 32'd0);
    check("t3_oor_err",  64'(error), 64'd1);
    check("t3_oor_data", 64'(d_rd), 64'hA5A50F0F);
    do_cmd("t3_hi", 4'd3, 32'h1000_0008, 32'd0);
    check("t3_hi_err", 64'(error), 64'd1);

    // Test 4: resume idempotence, register access while not paused, register 0, and register bounds.
    do_cmd("t4_res", 4'd2, 32'd0, 32'd0);
    check("t4_res", 64'({paused, error}), 64'b00);
    do_cmd("t4_res2", 4'd2, 32'd0, 32'd0);
    check("t4_res2", 64'({paused, error}), 64'b00);
    do_cmd("t4_wr5", 4'd6, 32'd5, 32'h55);
    check("t4_wr5_err", 64'(error), 64'd1);
    do_cmd("t4_pause", 4'd1, 32'd0, 32'd0);
    check("t4_pause", 64'({paused, error}), 64'b10);
    do_cmd("t4_rd5", 4'd5, 32'd5, 32'd0);
    check("t4_rd5", 64'({error, d_rd}), 64'({1'b0, 32'h0}));
    do_cmd("t4_wr0", 4'd6, 32'd0, 32'd7);
    check("t4_wr0_err", 64'(error), 64'd0);
    do_cmd("t4_wr31", 4'd6, 32'd31, 32'h12345678);
    do_cmd("t4_rd0", 4'd5, 32'd0, 32'd0);
    check("t4_rd0", 64'({error, d_rd}), 64'({1'b0, 32'h0}));
    do_cmd("t4_rd31", 4'd5, 32'd31, 32'd0);
    check("t4_rd31", 64'({error, d_rd}), 64'({1'b0, 32'h12345678}));
    do_cmd("t4_rd32", 4'd5, 32'd32, 32'd0);
    check("t4_rd32", 64'({error, d_rd}), 64'({1'b1, 32'h12345678}));
    do_cmd("t4_ill0", 4'd0, 32'd0, 32'd0);
    check("t4_ill0_err", 64'(error), 64'd1);
    do_cmd("t4_ill9", 4'd9, 32'd0, 32'd0);
    check("t4_ill9_err", 64'(error), 64'd1);
    do_cmd("t4_pause2", 4'd1, 32'd0, 32'd0);
    check("t4_pause2", 64'({paused, error}), 64'b10);
    check("t4_count", 64'(cmd_count), 64'd22);
    check("t4_hist",  64'(hist), 64'h5091);

    // Test 5: a strobe received while busy counts as overrun and is not accepted.
    issue(4'd5, 32'd31, 32'd0);
    @(posedge clk);
    @(posedge clk);
    issue(4'd1, 32'd0, 32'd0);
    wait_done("t5");
    check("t5_ovr",   64'(overrun), 64'd1);
    check("t5_count", 64'(cmd_count), 64'd23);
    check("t5_data",  64'(d_rd), 64'h12345678);
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("t5_extra_done", 64'(n_done), 64'd0);
    $display("overrun single: overrun=%0d count=%0d", overrun, cmd_count);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = 4'd1;
    repeat (400) @(negedge clk);
    cmd_valid = 1'b0;
    check("t5_ovr_sat", 64'(overrun), 64'hFF);
    $display("overrun saturation: overrun=%0h", overrun);
    repeat (12) @(negedge clk);

    // Test 6: a reset in the middle of MEM_WR aborts it.
    issue(4'd4, 32'h10, 32'hCAFEF00D);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_busy_pre", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy",  64'({busy, done}), 64'b00);
    check("t6_rst_pause", 64'(paused), 64'd0);
    check("t6_rst_ovr",   64'(overrun), 64'd0);
    check("t6_rst_count", 64'(cmd_count), 64'd0);
    check("t6_rst_hist",  64'(hist), 64'd0);
    check("t6_rst_out",   64'({error, d_rd}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_cmd("t6_rd_unp", 4'd3, 32'h10, 32'd0);
    check("t6_rd_unp_err", 64'(error), 64'd1);
    check("t6_count", 64'(cmd_count), 64'd1);
    do_cmd("t6_pause", 4'd1, 32'd0, 32'd0);
    do_cmd("t6_rd10", 4'd3, 32'h10, 32'd0);
    check("t6_rd10", 64'({error, d_rd}), 64'({1'b0, 32'h0}));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
